// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundles the program-memory port, the decoder-side
// valid/ready instruction stage, the redirect request and the halt/error status
// of the fetch sequencer.
//   master : sequencer side (drives pm_addr, instr*, halted, err)
//   slave  : environment side (drives pm_data, instr_ready, redir_*, resume)
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned INSTR_W = 14
);
    logic [ADDR_W-1:0]  pm_addr;
    logic [INSTR_W-1:0] pm_data;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               redir_valid;
    logic [1:0]         redir_op;
    logic [ADDR_W-1:0]  redir_addr;
    logic               resume;
    logic               halted;
    logic               err;

    modport master (
        output pm_addr, instr, instr_pc, instr_valid, halted, err,
        input  pm_data, instr_ready, redir_valid, redir_op, redir_addr, resume
    );

    modport slave (
        input  pm_addr, instr, instr_pc, instr_valid, halted, err,
        output pm_data, instr_ready, redir_valid, redir_op, redir_addr, resume
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller. Owns the PC, addresses a
// combinational program ROM, registers the returned word into a one-entry
// valid/ready stage, and handles JUMP/CALL/RET redirects (with a small return
// stack) plus halt/resume sequencing.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : fetch_sequencer_if.master (pm_addr/pm_data ROM port, instr/instr_pc/
//           instr_valid/instr_ready output stage, redir_valid/redir_op/redir_addr,
//           resume, halted, err)
// The interface instance must use the same ADDR_W/INSTR_W as this module.
module fetch_sequencer #(
    parameter int unsigned        ADDR_W       = 10,
    parameter int unsigned        INSTR_W      = 14,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
    parameter logic [INSTR_W-1:0] HALT_WORD    = INSTR_W'('h0404),
    parameter int unsigned        STACK_DEPTH  = 4
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam int unsigned SP_W  = IDX_W + 1;

    typedef enum logic [1:0] {StFetch, StHaltPend, StHalted, StError} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic               valid_q;
    logic [SP_W-1:0]    sp_q;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

    logic is_call, is_ret, redir_act, stack_fault;
    logic do_capture, do_flush, do_redirect, do_push, do_pop, halt_accept;
    logic halted, err;

    logic [IDX_W-1:0] push_idx, pop_idx;

    assign is_call   = bus.redir_op == 2'b01;
    assign is_ret    = bus.redir_op == 2'b10;
    assign push_idx  = sp_q[IDX_W-1:0];
    assign pop_idx   = IDX_W'(sp_q - SP_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect outranks capture, halt and resume
    always_comb begin
        state_d = state_q;
        if (redir_act) begin
            state_d = stack_fault ? StError : StFetch;
        end else begin
            unique case (state_q)
                StFetch:    if (do_capture && bus.pm_data == HALT_WORD) state_d = StHaltPend;
                StHaltPend: if (halt_accept) state_d = StHalted;
                StHalted:   if (bus.resume) state_d = StFetch;
                StError:    state_d = StError;
            endcase
        end
    end

    // Output / control strobes
    always_comb begin
        redir_act   = bus.redir_valid && (state_q != StError);
        stack_fault = redir_act &&
                      ((is_call && sp_q == SP_W'(STACK_DEPTH)) || (is_ret && sp_q == '0));
        do_redirect = redir_act && !stack_fault;
        do_push     = do_redirect && is_call;
        do_pop      = do_redirect && is_ret;
        // Capture only while the output stage is empty or being drained
        do_capture  = (state_q == StFetch) && !bus.redir_valid &&
                      (!valid_q || bus.instr_ready);
        halt_accept = (state_q == StHaltPend) && valid_q && bus.instr_ready;
        // A faulting redirect still flushes; ERROR never shows a valid word
        do_flush    = redir_act || halt_accept;
        halted      = state_q == StHalted;
        err         = state_q == StError;
    end

    // PC, output stage and stack pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            sp_q       <= '0;
        end else begin
            if (do_redirect) begin
                pc_q <= is_ret ? stack_q[pop_idx] : bus.redir_addr;
            end else if (do_capture) begin
                pc_q <= pc_q + ADDR_W'(1);
            end

            if (do_flush) begin
                valid_q <= 1'b0;
            end else if (do_capture) begin
                instr_q    <= bus.pm_data;
                instr_pc_q <= pc_q;
                valid_q    <= 1'b1;
            end

            if (do_push) begin
                sp_q <= sp_q + SP_W'(1);
            end else if (do_pop) begin
                sp_q <= sp_q - SP_W'(1);
            end
        end
    end

    // Return addresses need no reset; sp gates every read
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            stack_q[push_idx] <= instr_pc_q + ADDR_W'(1);
        end
    end

    assign bus.pm_addr     = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted;
    assign bus.err         = err;
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    localparam logic [13:0] HALT = 14'h0404;
    localparam int MRUN = 0, MPEND = 1, MHALTED = 2, MERR = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(10), .INSTR_W(14)) bus ();

    fetch_sequencer #(
        .ADDR_W(10), .INSTR_W(14), .RESET_VECTOR(10'h000),
        .HALT_WORD(14'h0404), .STACK_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [13:0] mem [1024];
    assign bus.pm_data = mem[bus.pm_addr];

    logic [13:0] prog [5] = '{14'h3000, 14'h3012, 14'h3013, 14'h3423, 14'h0404};

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: one fetch step per clock from the documented rules
    logic [9:0]  m_pc, m_ipc;
    logic [13:0] m_instr;
    logic        m_valid;
    int          m_mode;
    logic [9:0]  m_stack [$];

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 10'h000; m_ipc = '0; m_instr = '0; m_valid = 1'b0;
            m_mode = MRUN; m_stack.delete();
        end else if (m_mode == MERR) begin
            // frozen until reset
        end else if (bus.redir_valid) begin
            m_valid = 1'b0;
            m_mode  = MRUN;
            if (bus.redir_op == 2'b01) begin
                if (m_stack.size() == 4) m_mode = MERR;
                else begin
                    m_stack.push_back(m_ipc + 10'd1);
                    m_pc = bus.redir_addr;
                end
            end else if (bus.redir_op == 2'b10) begin
                if (m_stack.size() == 0) m_mode = MERR;
                else m_pc = m_stack.pop_back();
            end else begin
                m_pc = bus.redir_addr;
            end
        end else if (m_mode == MRUN) begin
            if (!m_valid || bus.instr_ready) begin
                m_instr = mem[m_pc];
                m_ipc   = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 10'd1;
                if (m_instr == HALT) m_mode = MPEND;
            end
        end else if (m_mode == MPEND) begin
            if (m_valid && bus.instr_ready) begin
                m_valid = 1'b0;
                m_mode  = MHALTED;
            end
        end else if (m_mode == MHALTED) begin
            if (bus.resume) m_mode = MRUN;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("pm_addr", bus.pm_addr, m_pc);
            chk("instr_valid", bus.instr_valid, m_valid);
            chk("instr", bus.instr, m_instr);
            chk("instr_pc", bus.instr_pc, m_ipc);
            chk("halted", bus.halted, m_mode == MHALTED);
            chk("err", bus.err, m_mode == MERR);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_in();
        bus.instr_ready = 1'b1; bus.redir_valid = 1'b0; bus.redir_op = 2'b00;
        bus.redir_addr = '0; bus.resume = 1'b0;
    endtask

    task automatic redir(input logic [1:0] op, input logic [9:0] addr);
        bus.redir_valid = 1'b1; bus.redir_op = op; bus.redir_addr = addr;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 5; i++) mem[i] = prog[i];
    endtask

    // Holds reset for one clock; returns at the negedge of cycle 0
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_instr(input string name, input logic [9:0] pc, input logic [13:0] w);
        chk({name, ".valid"}, bus.instr_valid, 1'b1);
        chk({name, ".pc"}, bus.instr_pc, pc);
        chk({name, ".instr"}, bus.instr, w);
    endtask

    logic [9:0] targets [5] = '{10'h020, 10'h040, 10'h060, 10'h080, 10'h0A0};

    initial begin
        load_prog();
        idle_in();
        reset = 1'b1;
        cyc(2);
        check_en = 1'b1;

        // Straight-line program up to the halt word, then resume
        do_reset();
        chk("rst.valid", bus.instr_valid, 1'b0);
        chk("rst.pm_addr", bus.pm_addr, 10'h000);
        chk("rst.halted", bus.halted, 1'b0);
        chk("rst.err", bus.err, 1'b0);
        chk("rst.instr", bus.instr, 14'h0000);
        chk("rst.instr_pc", bus.instr_pc, 10'h000);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk_instr("seq", 10'(i), prog[i]);
        end
        cyc(1);
        chk("halt.halted", bus.halted, 1'b1);
        chk("halt.valid", bus.instr_valid, 1'b0);
        chk("halt.pm_addr", bus.pm_addr, 10'h005);
        cyc(1);
        chk("halt2.pm_addr", bus.pm_addr, 10'h005);
        bus.resume = 1'b1;
        cyc(1);
        bus.resume = 1'b0;
        chk("resume.halted", bus.halted, 1'b0);
        chk("resume.valid", bus.instr_valid, 1'b0);
        cyc(1);
        chk_instr("resume", 10'h005, 14'h0000);

        // Backpressure in cycles 2-4
        do_reset();
        cyc(2);
        for (int c = 2; c <= 4; c++) begin
            chk_instr("stall", 10'h001, 14'h3012);
            chk("stall.pm_addr", bus.pm_addr, 10'h002);
            bus.instr_ready = 1'b0;
            cyc(1);
        end
        bus.instr_ready = 1'b1;
        chk_instr("stall_end", 10'h001, 14'h3012);
        cyc(1);
        chk_instr("after_stall", 10'h002, 14'h3013);

        // Resume and JUMP together while halted: JUMP wins
        do_reset();
        cyc(6);
        chk("halt_b.halted", bus.halted, 1'b1);
        bus.resume = 1'b1;
        redir(2'b00, 10'h001);
        cyc(1);
        idle_in();
        chk("jmp_res.halted", bus.halted, 1'b0);
        chk("jmp_res.valid", bus.instr_valid, 1'b0);
        chk("jmp_res.pm_addr", bus.pm_addr, 10'h001);
        cyc(1);
        chk_instr("jmp_res", 10'h001, 14'h3012);

        // JUMP to the top address wraps
        do_reset();
        cyc(3);
        chk_instr("pre_jmp", 10'h002, 14'h3013);
        redir(2'b00, 10'h3FF);
        cyc(1);
        idle_in();
        chk("jmp.flush", bus.instr_valid, 1'b0);
        cyc(1);
        chk_instr("jmp.top", 10'h3FF, 14'h0000);
        cyc(1);
        chk_instr("jmp.wrap", 10'h000, 14'h3000);

        // CALL then RET
        do_reset();
        cyc(1);
        redir(2'b00, 10'h010);
        cyc(1);
        idle_in();
        cyc(1);
        chk("call.at", bus.instr_pc, 10'h010);
        redir(2'b01, 10'h100);
        cyc(1);
        idle_in();
        cyc(1);
        chk_instr("call.tgt", 10'h100, 14'h0000);
        redir(2'b10, 10'h000);
        cyc(1);
        idle_in();
        cyc(1);
        chk_instr("ret", 10'h011, 14'h0000);

        // Five nested CALLs overflow a four-deep stack
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            redir(2'b01, targets[k]);
            cyc(1);
            idle_in();
        end
        chk("ovf.err", bus.err, 1'b1);
        chk("ovf.valid", bus.instr_valid, 1'b0);
        chk("ovf.pm_addr", bus.pm_addr, 10'h081);
        bus.resume = 1'b1;
        redir(2'b00, 10'h123);
        cyc(3);
        idle_in();
        chk("ovf2.err", bus.err, 1'b1);
        chk("ovf2.pm_addr", bus.pm_addr, 10'h081);
        chk("ovf2.valid", bus.instr_valid, 1'b0);

        // RET on empty stack, then reset clears the error
        do_reset();
        cyc(1);
        redir(2'b10, 10'h000);
        cyc(1);
        idle_in();
        chk("unf.err", bus.err, 1'b1);
        chk("unf.valid", bus.instr_valid, 1'b0);
        do_reset();
        chk("unf_rst.err", bus.err, 1'b0);
        cyc(1);
        chk_instr("unf_rst", 10'h000, 14'h3000);

        // Randomised traffic against the model
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 11) == 0) ? HALT : 14'($urandom);
        for (int n = 0; n < 4000; n++) begin
            cyc(1);
            bus.instr_ready = $urandom_range(0, 3) != 0;
            bus.redir_valid = $urandom_range(0, 11) == 0;
            bus.redir_op    = 2'($urandom);
            bus.redir_addr  = 10'($urandom);
            bus.resume      = $urandom_range(0, 3) == 0;
            reset           = $urandom_range(0, 149) == 0;
        end
        cyc(1);
        idle_in();
        reset = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
